bp_be_branch_resolver: RTL and testbench
========================================

# bp_be_branch_resolver

Backend-side producer of branch resolutions for the frontend PC generator. It accepts executed control-flow outcomes from the BE pipeline and classifies each one as taken/not-taken and hit/miss against the predicted next PC. It buffers the resolutions in program order and drives the frontend's resolve valid/yumi interface. After a misprediction it stalls wrong-path resolutions until the redirect has been consumed.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg: processor config; supplies vaddr_width_p and branch_metadata_fwd_width_p
- fifo_els_p, 4: resolution buffer depth (power of 2, ≥2)

Ports:
- clk_i  in  1  clock; single clock domain
- reset_i  in  1  synchronous, active-high reset
- br_v_i  in  1  executed control-flow resolution valid
- br_ready_o  out  1  resolver can accept br_v_i this cycle
- br_pc_i  in  vaddr_width_p  PC of the resolved instruction
- br_npc_i  in  vaddr_width_p  architecturally correct next PC
- br_pred_npc_i  in  vaddr_width_p  next PC the frontend fetched after this instruction
- br_nonbr_i  in  1  instruction was predicted as control flow but is not a branch
- br_metadata_i  in  branch_metadata_fwd_width_p  metadata forwarded by the FE with the fetch
- flush_i  in  1  BE trap/exception flush; discards buffered resolutions
- resolve_pc_o  out  vaddr_width_p  redirect/training target (= br_npc_i of head)
- resolve_miss_o  out  1  head was mispredicted
- resolve_taken_o  out  1  head was taken
- resolve_nonbr_o  out  1  head is a non-branch
- resolve_br_metadata_o  out  branch_metadata_fwd_width_p  head metadata, passed through unmodified
- resolve_v_o  out  1  head valid
- resolve_yumi_i  in  1  FE consumed the head; asserted only when resolve_v_o=1
- redirect_pending_o  out  1  a mispredict is buffered and not yet consumed
- mispredict_cnt_o  out  32  saturating count of enqueued mispredicts

## Operation
- Classification on enqueue:
  - taken = (br_npc_i != br_pc_i + 4). The sum is modulo 2^vaddr_width_p, so it wraps.
  - miss = (br_npc_i != br_pred_npc_i).
  - nonbr = br_nonbr_i.
- Enqueue condition: br_v_i & br_ready_o. An entry holds {npc, miss, taken, nonbr, metadata}. br_pc_i itself is not stored.
- FIFO is strictly in order, with circular read/write pointers plus a count (0..fifo_els_p). Pointers wrap from fifo_els_p-1 to 0.
- Outputs: resolve_v_o = (count != 0). The resolve_* data outputs reflect the head entry and are forced to 0 when resolve_v_o=0.
- Dequeue condition: resolve_v_o & resolve_yumi_i.
- State machine:
  - e_run: br_ready_o = (count != fifo_els_p). Enqueuing an entry with miss=1 moves to e_miss.
  - e_miss: br_ready_o=0, so wrong-path resolutions are held off. Dequeuing the entry with miss=1 returns to e_run. Only one miss is ever buffered, and it is always the youngest entry.
- redirect_pending_o = (state == e_miss).
- mispredict_cnt_o increments by 1 on each enqueue with miss=1. It saturates at 0xFFFF_FFFF. flush_i does not clear it.
- flush_i:
  - Next cycle: count=0, pointers=0, state=e_run.
  - An enqueue in the same cycle is dropped, and mispredict_cnt_o is not incremented for it.
  - A dequeue in the same cycle still counts as consumed by the FE.
- Simultaneous enqueue and dequeue: allowed whenever br_ready_o=1, and count is unchanged. br_ready_o does not depend on resolve_yumi_i, so there is no combinational path from yumi to ready. A full FIFO rejects input even if a dequeue occurs in the same cycle.
- Enqueue into an empty FIFO does not bypass: resolve_v_o rises on the next cycle.

## Timing
- Reset values (cycle after reset_i): count=0, state=e_run, resolve_v_o=0, all resolve_* data = 0, br_ready_o=1, redirect_pending_o=0, mispredict_cnt_o=0.
- Reset mid-operation discards all entries, the same as flush_i, and also clears the counter.
- Latency: enqueue at cycle N gives resolve_v_o=1 at N+1 when the FIFO was empty.
- Throughput: one enqueue and one dequeue per cycle.
- Head data is stable while resolve_v_o=1 and resolve_yumi_i=0.
- On a miss enqueued at N: redirect_pending_o=1 and br_ready_o=0 from N+1. If yumi of that entry arrives at cycle M, both return to e_run values at M+1.
- All outputs are registered or derived from registered state only, with no input-to-output combinational paths.

## Test plan
- Correct not-taken (vaddr 39): pc=0x80000000, npc=0x80000004, pred=0x80000004 -> next cycle resolve_v_o=1, miss=0, taken=0, resolve_pc_o=0x80000004; yumi -> resolve_v_o=0.
- Mispredict: pc=0x1000, npc=0x2000, pred=0x1004 -> miss=1, taken=1, redirect_pending_o=1, br_ready_o=0, cnt=1. Hold yumi low 5 cycles -> outputs stable. Yumi -> br_ready_o=1 and redirect_pending_o=0 the next cycle.
- Backpressure/full: 4 correct resolutions with yumi=0 -> br_ready_o=0 after the 4th. Next, yumi and br_v_i in the same cycle -> input rejected. Drain -> the 4 entries appear in order, with resolve_pc_o matching each npc.
- Wrap: pc=0x7F_FFFF_FFFC, npc=0x0 -> taken=0. Then pc=0x7F_FFFF_FFFC, npc=0x100 -> taken=1.
- Flush: 3 buffered entries including a tail miss, flush_i together with yumi and br_v_i -> next cycle resolve_v_o=0, state e_run, dropped input absent, cnt unchanged.
- Counter saturation: force cnt to 0xFFFFFFFE, enqueue 2 misses -> cnt=0xFFFFFFFF and holds.

Source files
------------

// File: rtl/bp_be_branch_resolver.sv
// Backend branch resolver: classifies executed control flow as taken/miss, buffers the
// resolutions in program order and holds off wrong-path resolutions until a redirect drains.
module bp_be_branch_resolver #(
  parameter int unsigned vaddr_width_p               = 39,
  parameter int unsigned branch_metadata_fwd_width_p = 36,
  parameter int unsigned fifo_els_p                  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic                                   br_v_i,
  output logic                                   br_ready_o,
  input  logic [vaddr_width_p-1:0]               br_pc_i,
  input  logic [vaddr_width_p-1:0]               br_npc_i,
  input  logic [vaddr_width_p-1:0]               br_pred_npc_i,
  input  logic                                   br_nonbr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_i,

  input  logic                                   flush_i,

  output logic [vaddr_width_p-1:0]               resolve_pc_o,
  output logic                                   resolve_miss_o,
  output logic                                   resolve_taken_o,
  output logic                                   resolve_nonbr_o,
  output logic [branch_metadata_fwd_width_p-1:0] resolve_br_metadata_o,
  output logic                                   resolve_v_o,
  input  logic                                   resolve_yumi_i,

  output logic                                   redirect_pending_o,
  output logic [31:0]                            mispredict_cnt_o
);

  localparam int unsigned VW    = vaddr_width_p;
  localparam int unsigned MW    = branch_metadata_fwd_width_p;
  localparam int unsigned PTR_W = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int unsigned CNT_W = $clog2(fifo_els_p + 1);

  typedef struct packed {
    logic [VW-1:0] npc;
    logic          miss;
    logic          taken;
    logic          nonbr;
    logic [MW-1:0] metadata;
  } entry_s;

  typedef enum logic [0:0] {
    e_run  = 1'b0,
    e_miss = 1'b1
  } state_e;

  state_e             state_q, state_n;
  entry_s             mem_q [fifo_els_p];
  logic [PTR_W-1:0]   rptr_q, wptr_q;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [31:0]        mispredict_cnt_q;

  entry_s             enq_entry;
  entry_s             head;
  logic               enq;
  logic               deq;
  logic               not_full;

  // Classification of the incoming resolution
  always_comb begin
    enq_entry          = '0;
    enq_entry.npc      = br_npc_i;
    enq_entry.miss     = (br_npc_i != br_pred_npc_i);
    enq_entry.taken    = (br_npc_i != VW'(br_pc_i + VW'(4)));
    enq_entry.nonbr    = br_nonbr_i;
    enq_entry.metadata = br_metadata_i;
  end

  assign not_full    = (count_q != CNT_W'(fifo_els_p));
  assign resolve_v_o = (count_q != '0);
  assign head        = mem_q[rptr_q];
  assign enq         = br_v_i & br_ready_o & ~flush_i;
  assign deq         = resolve_v_o & resolve_yumi_i;

  // Next state and ready; ready depends only on registered state
  always_comb begin
    state_n    = state_q;
    br_ready_o = 1'b0;
    unique case (state_q)
      e_run: begin
        br_ready_o = not_full;
        if (enq && enq_entry.miss) state_n = e_miss;
      end
      e_miss: begin
        br_ready_o = 1'b0;
        if (deq && head.miss) state_n = e_run;
      end
      default: state_n = e_run;
    endcase
    if (flush_i) state_n = e_run;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_run;
    else         state_q <= state_n;
  end

  always_comb begin
    count_n = count_q;
    unique case ({enq, deq})
      2'b10:   count_n = CNT_W'(count_q + CNT_W'(1));
      2'b01:   count_n = CNT_W'(count_q - CNT_W'(1));
      default: count_n = count_q;
    endcase
  end

  // Circular pointers and occupancy; flush discards everything
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_n;
      if (enq) wptr_q <= (wptr_q == PTR_W'(fifo_els_p - 1)) ? '0 : PTR_W'(wptr_q + PTR_W'(1));
      if (deq) rptr_q <= (rptr_q == PTR_W'(fifo_els_p - 1)) ? '0 : PTR_W'(rptr_q + PTR_W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= enq_entry;
  end

  // Saturating mispredict counter, survives flush
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mispredict_cnt_q <= '0;
    end else if (enq && enq_entry.miss && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
      mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt_o      = mispredict_cnt_q;
  assign redirect_pending_o    = (state_q == e_miss);
  assign resolve_pc_o          = resolve_v_o ? head.npc      : '0;
  assign resolve_miss_o        = resolve_v_o & head.miss;
  assign resolve_taken_o       = resolve_v_o & head.taken;
  assign resolve_nonbr_o       = resolve_v_o & head.nonbr;
  assign resolve_br_metadata_o = resolve_v_o ? head.metadata : '0;

endmodule

// File: tb/tb_bp_be_branch_resolver.sv
// Directed testbench for bp_be_branch_resolver with hand-computed expectations.
module tb_bp_be_branch_resolver;

  localparam int unsigned VW = 39;
  localparam int unsigned MW = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic          br_v, br_ready, br_nonbr, flush;
  logic [VW-1:0] br_pc, br_npc, br_pred_npc;
  logic [MW-1:0] br_metadata;
  logic [VW-1:0] resolve_pc;
  logic          resolve_miss, resolve_taken, resolve_nonbr, resolve_v, resolve_yumi;
  logic [MW-1:0] resolve_br_metadata;
  logic          redirect_pending;
  logic [31:0]   mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_be_branch_resolver #(
    .vaddr_width_p              (VW),
    .branch_metadata_fwd_width_p(MW),
    .fifo_els_p                 (4)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .br_v_i               (br_v),
    .br_ready_o           (br_ready),
    .br_pc_i              (br_pc),
    .br_npc_i             (br_npc),
    .br_pred_npc_i        (br_pred_npc),
    .br_nonbr_i           (br_nonbr),
    .br_metadata_i        (br_metadata),
    .flush_i              (flush),
    .resolve_pc_o         (resolve_pc),
    .resolve_miss_o       (resolve_miss),
    .resolve_taken_o      (resolve_taken),
    .resolve_nonbr_o      (resolve_nonbr),
    .resolve_br_metadata_o(resolve_br_metadata),
    .resolve_v_o          (resolve_v),
    .resolve_yumi_i       (resolve_yumi),
    .redirect_pending_o   (redirect_pending),
    .mispredict_cnt_o     (mispredict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [VW-1:0] pc, input logic [VW-1:0] npc,
                       input logic [VW-1:0] pred, input logic nonbr, input logic [MW-1:0] md);
    br_v        = 1'b1;
    br_pc       = pc;
    br_npc      = npc;
    br_pred_npc = pred;
    br_nonbr    = nonbr;
    br_metadata = md;
  endtask

  initial begin
    reset = 1'b1; br_v = 1'b0; br_pc = '0; br_npc = '0; br_pred_npc = '0;
    br_nonbr = 1'b0; br_metadata = '0; flush = 1'b0; resolve_yumi = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_v",       64'(resolve_v), 64'd0);
    check("rst_ready",   64'(br_ready), 64'd1);
    check("rst_pending", 64'(redirect_pending), 64'd0);
    check("rst_cnt",     64'(mispredict_cnt), 64'd0);
    check("rst_pc",      64'(resolve_pc), 64'd0);
    check("rst_flags",   64'({resolve_miss, resolve_taken, resolve_nonbr}), 64'd0);
    check("rst_md",      64'(resolve_br_metadata), 64'd0);

    // Correct not-taken
    drive(39'h80000000, 39'h80000004, 39'h80000004, 1'b0, 36'h5A);
    tick(); br_v = 1'b0;
    check("nt_v",     64'(resolve_v), 64'd1);
    check("nt_miss",  64'(resolve_miss), 64'd0);
    check("nt_taken", 64'(resolve_taken), 64'd0);
    check("nt_pc",    64'(resolve_pc), 64'h80000004);
    check("nt_md",    64'(resolve_br_metadata), 64'h5A);
    resolve_yumi = 1'b1; tick(); resolve_yumi = 1'b0;
    check("nt_drain_v",  64'(resolve_v), 64'd0);
    check("nt_drain_pc", 64'(resolve_pc), 64'd0);

    // Mispredict, wrong path held off while redirect pending
    drive(39'h1000, 39'h2000, 39'h1004, 1'b1, 36'h33);
    tick();
    drive(39'h2000, 39'h2004, 39'h2004, 1'b0, 36'h44);
    check("mp_miss",    64'(resolve_miss), 64'd1);
    check("mp_taken",   64'(resolve_taken), 64'd1);
    check("mp_nonbr",   64'(resolve_nonbr), 64'd1);
    check("mp_pending", 64'(redirect_pending), 64'd1);
    check("mp_ready",   64'(br_ready), 64'd0);
    check("mp_cnt",     64'(mispredict_cnt), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mp_hold_pc",    64'(resolve_pc), 64'h2000);
      check("mp_hold_ready", 64'(br_ready), 64'd0);
    end
    br_v = 1'b0;
    resolve_yumi = 1'b1; tick(); resolve_yumi = 1'b0;
    check("mp_rel_ready",   64'(br_ready), 64'd1);
    check("mp_rel_pending", 64'(redirect_pending), 64'd0);
    check("mp_rel_v",       64'(resolve_v), 64'd0);
    check("mp_rel_cnt",     64'(mispredict_cnt), 64'd1);

    // Fill to full, then a rejected enqueue alongside a dequeue
    for (int i = 0; i < 4; i++) begin
      drive(39'(39'h3000 + i * 16 - 4), 39'(39'h3000 + i * 16), 39'(39'h3000 + i * 16), 1'b0, 36'(i));
      tick();
      check("full_ready", 64'(br_ready), (i == 3) ? 64'd0 : 64'd1);
    end
    check("full_head", 64'(resolve_pc), 64'h3000);
    drive(39'h9995, 39'h9999, 39'h9999, 1'b0, 36'hF);
    resolve_yumi = 1'b1;
    tick();
    br_v = 1'b0;
    check("full_after_ready", 64'(br_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      check("drain_pc", 64'(resolve_pc), 64'(39'h3000 + i * 16));
      check("drain_md", 64'(resolve_br_metadata), 64'(i));
      tick();
    end
    resolve_yumi = 1'b0;
    check("drain_empty", 64'(resolve_v), 64'd0);

    // Address wrap in pc+4
    drive(39'h7F_FFFF_FFFC, 39'h0, 39'h0, 1'b0, 36'h1);
    tick();
    check("wrap_taken0", 64'(resolve_taken), 64'd0);
    check("wrap_v",      64'(resolve_v), 64'd1);
    drive(39'h7F_FFFF_FFFC, 39'h100, 39'h100, 1'b0, 36'h2);
    resolve_yumi = 1'b1;
    tick();
    br_v = 1'b0;
    check("wrap_taken1", 64'(resolve_taken), 64'd1);
    check("wrap_pc",     64'(resolve_pc), 64'h100);
    check("wrap_miss",   64'(resolve_miss), 64'd0);
    tick();
    resolve_yumi = 1'b0;
    check("wrap_empty", 64'(resolve_v), 64'd0);

    // Flush with a buffered tail miss
    drive(39'h3ffc, 39'h4000, 39'h4000, 1'b0, 36'h0); tick();
    drive(39'h400c, 39'h4010, 39'h4010, 1'b0, 36'h0); tick();
    drive(39'h4020, 39'h5000, 39'h4024, 1'b0, 36'h0); tick();
    check("fl_pending_pre", 64'(redirect_pending), 64'd1);
    check("fl_cnt_pre",     64'(mispredict_cnt), 64'd2);
    drive(39'h6000, 39'h7000, 39'h6004, 1'b0, 36'h0);
    flush = 1'b1; resolve_yumi = 1'b1;
    tick();
    flush = 1'b0; resolve_yumi = 1'b0; br_v = 1'b0;
    check("fl_v",       64'(resolve_v), 64'd0);
    check("fl_pending", 64'(redirect_pending), 64'd0);
    check("fl_ready",   64'(br_ready), 64'd1);
    check("fl_cnt",     64'(mispredict_cnt), 64'd2);
    // Flush drops an accepted-looking miss enqueue in run state
    drive(39'h6000, 39'h7000, 39'h6004, 1'b0, 36'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; br_v = 1'b0;
    check("fl2_v",       64'(resolve_v), 64'd0);
    check("fl2_pending", 64'(redirect_pending), 64'd0);
    check("fl2_cnt",     64'(mispredict_cnt), 64'd2);

    // Counter saturation
    force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_cnt_q;
    check("sat_preload", 64'(mispredict_cnt), 64'hFFFF_FFFE);
    drive(39'h100, 39'h200, 39'h104, 1'b0, 36'h0);
    tick(); br_v = 1'b0;
    check("sat_cnt1", 64'(mispredict_cnt), 64'hFFFF_FFFF);
    resolve_yumi = 1'b1; tick(); resolve_yumi = 1'b0;
    drive(39'h100, 39'h200, 39'h104, 1'b0, 36'h0);
    tick(); br_v = 1'b0;
    check("sat_cnt2", 64'(mispredict_cnt), 64'hFFFF_FFFF);
    tick();
    check("sat_hold", 64'(mispredict_cnt), 64'hFFFF_FFFF);

    // Reset mid-operation clears entries and counter
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_v",       64'(resolve_v), 64'd0);
    check("mid_rst_cnt",     64'(mispredict_cnt), 64'd0);
    check("mid_rst_pending", 64'(redirect_pending), 64'd0);
    check("mid_rst_ready",   64'(br_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
